// File: rtl/ad9228_pkg.sv
// ---------------------------------------------------------------------------
// ad9228_pkg : shared types and constants for the AD9228 serial TX emulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ad9228_pkg;

  localparam int N_LANES  = 4;
  localparam int BITS     = 12;
  localparam int FCO_HIGH = 6;
  localparam int UCNT_W   = 16;
  localparam int CNT_W    = $clog2(BITS);

  typedef logic [BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    PAT_USER    = 2'b00,
    PAT_RAMP    = 2'b01,
    PAT_CHECKER = 2'b10,
    PAT_FIXED   = 2'b11
  } pattern_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  localparam sample_t CHECKER_A = 12'hAAA;
  localparam sample_t CHECKER_B = 12'h555;
  localparam sample_t MIDSCALE  = 12'h800;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);
  localparam logic [CNT_W-1:0] FCO_LIM  = CNT_W'(FCO_HIGH);

  // Test-pattern word for one lane; ramp_val already carries the lane offset.
  function automatic sample_t pattern_word(input pattern_e mode, input sample_t ramp_val,
                                           input logic phase);
    sample_t w;
    case (mode)
      PAT_RAMP:    w = ramp_val;
      PAT_CHECKER: w = phase ? CHECKER_B : CHECKER_A;
      PAT_FIXED:   w = MIDSCALE;
      default:     w = '0;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ad9228_lane_ser.sv
// ---------------------------------------------------------------------------
// ad9228_lane_ser : one lane's frame register and registered serial output
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad9228_lane_ser
  import ad9228_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  sample_t          load_val_i,
  input  logic             out_en_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic             din_o
);

  sample_t          shift_q, shift_d;
  logic             din_q, din_d;
  logic [CNT_W-1:0] sel;

  // The frame register is indexed rather than shifted, so a new frame can load
  // on the same edge that the previous frame's last bit is registered out.
  assign sel = LAST_BIT - idx_i;

  always_comb begin
    shift_d = shift_q;
    din_d   = 1'b0;
    if (load_i) begin
      shift_d = load_val_i;
    end
    if (out_en_i) begin
      din_d = shift_q[sel];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= '0;
      din_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      din_q   <= din_d;
    end
  end

  assign din_o = din_q;

endmodule

`default_nettype wire

// File: rtl/ad9228_lvds_tx_emulator.sv
// ---------------------------------------------------------------------------
// ad9228_lvds_tx_emulator : AD9228 serial-output emulator (din/fco/dco)
// Optional test patterns enabled by defining AD9228_TX_PATTERN_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ad9228_lvds_tx_emulator
  import ad9228_pkg::*;
(
  input  logic                    aclk_i,
  input  logic                    arstn_i,
  input  logic                    en_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [N_LANES*BITS-1:0] s_data_i,
  input  logic [1:0]              pattern_mode_i,
  output logic [N_LANES-1:0]      din_o,
  output logic                    fco_o,
  output logic                    dco_o,
  output logic                    frame_start_o,
  output logic                    underrun_o,
  output logic [UCNT_W-1:0]       underrun_cnt_o
);

  tx_state_e                state_q;
  logic [CNT_W-1:0]         bit_cnt_q;
  logic                     stage_vld_q;
  logic [CNT_W-1:0]         stage_idx_q;
  logic                     fco_q;
  logic                     dco_q;
  logic                     fs_q;

  logic [N_LANES*BITS-1:0]  hold_q, hold_d;
  logic                     hold_full_q, hold_full_d;
  logic [N_LANES*BITS-1:0]  last_q, last_d;
  logic                     underrun_q, underrun_d;
  logic [UCNT_W-1:0]        ucnt_q, ucnt_d;

  logic                     load_now;
  logic                     accept;
  logic                     pattern_active;
  logic [N_LANES*BITS-1:0]  user_val;
  logic [N_LANES*BITS-1:0]  load_val;

  assign load_now  = (state_q == ST_RUN) && (bit_cnt_q == '0);
  assign s_ready_o = !hold_full_q || load_now;
  assign accept    = s_valid_i && s_ready_o;
  assign user_val  = hold_full_q ? hold_q : last_q;

`ifdef AD9228_TX_PATTERN_EN
  pattern_e mode;
  sample_t  ramp_q, ramp_d;
  logic     phase_q, phase_d;

  assign mode           = pattern_e'(pattern_mode_i);
  assign pattern_active = (mode != PAT_USER);

  always_comb begin
    ramp_d  = ramp_q;
    phase_d = phase_q;
    if (load_now) begin
      if (mode == PAT_RAMP) begin
        ramp_d = ramp_q + 1'b1;
      end
      if (mode == PAT_CHECKER) begin
        phase_d = !phase_q;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!arstn_i) begin
      ramp_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      ramp_q  <= ramp_d;
      phase_q <= phase_d;
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_pat
    assign load_val[l*BITS +: BITS] = pattern_active
        ? pattern_word(mode, ramp_q + sample_t'(l), phase_q)
        : user_val[l*BITS +: BITS];
  end
`else
  logic pattern_unused;
  assign pattern_unused = ^pattern_mode_i;
  assign pattern_active = 1'b0;
  assign load_val       = user_val;
`endif

  // Holding register, replay register and underrun accounting. When accept and
  // load coincide the load consumes the old word and the new one takes its place.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;
    if (load_now) begin
      hold_full_d = 1'b0;
      if (hold_full_q) begin
        last_d = hold_q;
      end else if (!pattern_active) begin
        underrun_d = 1'b1;
        if (ucnt_q != '1) begin
          ucnt_d = ucnt_q + 1'b1;
        end
      end
    end
    if (accept) begin
      hold_d      = s_data_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!arstn_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  // Frame FSM plus the output stage; stage_* delays the bit index by one cycle
  // so fco/dco/frame_start line up with the lane din registers.
  always_ff @(posedge aclk_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      stage_vld_q <= 1'b0;
      stage_idx_q <= '0;
      fco_q       <= 1'b0;
      dco_q       <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      stage_vld_q <= (state_q == ST_RUN);
      stage_idx_q <= bit_cnt_q;
      fco_q       <= stage_vld_q && (stage_idx_q < FCO_LIM);
      dco_q       <= stage_vld_q && ((stage_idx_q == '0) || !dco_q);
      fs_q        <= stage_vld_q && (stage_idx_q == '0);
      case (state_q)
        ST_IDLE: begin
          bit_cnt_q <= '0;
          if (en_i) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_q <= '0;
            if (!en_i) begin
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    ad9228_lane_ser u_ser (
      .clk_i      (aclk_i),
      .rst_ni     (arstn_i),
      .load_i     (load_now),
      .load_val_i (load_val[l*BITS +: BITS]),
      .out_en_i   (stage_vld_q),
      .idx_i      (stage_idx_q),
      .din_o      (din_o[l])
    );
  end

  assign fco_o          = fco_q;
  assign dco_o          = dco_q;
  assign frame_start_o  = fs_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ad9228_lvds_tx_emulator.sv
// ---------------------------------------------------------------------------
// tb_ad9228_lvds_tx_emulator : directed self-checking bench for the TX emulator
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ad9228_lvds_tx_emulator;

  logic        aclk;
  logic        arstn;
  logic        en;
  logic        s_valid;
  logic        s_ready;
  logic [47:0] s_data;
  logic [1:0]  pattern_mode;
  logic [3:0]  din;
  logic        fco;
  logic        dco;
  logic        frame_start;
  logic        underrun;
  logic [15:0] underrun_cnt;

  ad9228_lvds_tx_emulator dut (
    .aclk_i         (aclk),
    .arstn_i        (arstn),
    .en_i           (en),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .s_data_i       (s_data),
    .pattern_mode_i (pattern_mode),
    .din_o          (din),
    .fco_o          (fco),
    .dco_o          (dco),
    .frame_start_o  (frame_start),
    .underrun_o     (underrun),
    .underrun_cnt_o (underrun_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          fpos;
  int          fs_cnt;
  int          frames_done;
  int          ur_pulses;
  bit          chk;
  logic [47:0] cur;
  logic [47:0] last_frame;
  logic [47:0] exp_last;
  logic [11:0] fco_pat;
  logic [11:0] dco_pat;
  logic [11:0] last_fco;
  logic [11:0] last_dco;
  logic [47:0] exp_q[$];
  logic [47:0] frames_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] wgen(input int i);
    logic [11:0] a, b, c, d;
    a = 12'(i * 7);
    b = 12'(i * 13 + 12'h5A0);
    c = 12'(i * 101 + 7);
    d = 12'(i * 37 + 3);
    return {d, c, b, a};
  endfunction

  // One negedge; the output monitor assembles frames and, when chk is set,
  // compares each against the next expected word (replaying the last on starve).
  task automatic tick();
    logic [47:0] e;
    @(negedge aclk);
    cyc++;
    if (underrun === 1'b1) ur_pulses++;
    if (frame_start === 1'b1) begin
      fpos = 0;
      fs_cnt++;
    end
    if (fpos >= 0) begin
      for (int l = 0; l < 4; l++) cur[l*12 + 11 - fpos] = din[l];
      fco_pat[11 - fpos] = fco;
      dco_pat[11 - fpos] = dco;
      if (fpos == 11) begin
        last_frame = cur;
        last_fco   = fco_pat;
        last_dco   = dco_pat;
        frames_q.push_back(cur);
        frames_done++;
        fpos = -1;
        if (chk) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : exp_last;
          exp_last = e;
          check("frame", 64'(cur), 64'(e));
        end
      end else begin
        fpos++;
      end
    end
  endtask

  task automatic start_section();
    fpos = -1;
    fs_cnt = 0;
    frames_done = 0;
    ur_pulses = 0;
    chk = 1'b0;
    exp_last = '0;
    exp_q.delete();
    frames_q.delete();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    en = 1'b0;
    s_valid = 1'b0;
    repeat (3) tick();
    arstn = 1'b1;
    start_section();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] w;
    int idx, acc, bad_gap, last_acc;
    bit pending;

    n_cmp = 0; n_fail = 0; cyc = 0;
    arstn = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; pattern_mode = 2'b00;
    start_section();

    // Reset state
    repeat (5) tick();
    check("rst_din", 64'(din), 64'h0);
    check("rst_fco_dco", 64'({fco, dco}), 64'h0);
    check("rst_fs_ur", 64'({frame_start, underrun}), 64'h0);
    check("rst_cnt", 64'(underrun_cnt), 64'h0);
    check("rst_ready", 64'(s_ready), 64'h1);
    arstn = 1'b1;
    tick();

    // Single word, lane3..0 = 000,FFF,123,ABC
    start_section();
    chk = 1'b1;
    s_data = 48'h000_FFF_123_ABC;
    s_valid = 1'b1;
    en = 1'b1;
    check("single_ready", 64'(s_ready), 64'h1);
    exp_q.push_back(s_data);
    tick();
    s_valid = 1'b0;
    tick();
    check("lat_fs_early", 64'(frame_start), 64'h0);
    tick();
    check("lat_fs", 64'(frame_start), 64'h1);
    en = 1'b0;
    for (int c = 0; c < 30 && frames_done < 1; c++) tick();
    check("single_frames", 64'(frames_done), 64'd1);
    check("single_lane0", 64'(last_frame[11:0]), 64'hABC);
    check("single_lane2", 64'(last_frame[35:24]), 64'hFFF);
    check("single_fco", 64'(last_fco), 64'hFC0);
    check("single_dco", 64'(last_dco), 64'hAAA);
    check("single_fs_cnt", 64'(fs_cnt), 64'd1);
    tick();
    check("single_idle_out", 64'({din, fco, dco}), 64'h0);
    check("single_no_ur", 64'(underrun_cnt), 64'h0);

    // Stream 100 words with s_valid held high
    do_reset();
    chk = 1'b1;
    idx = 0; acc = 0; bad_gap = 0; last_acc = 0; pending = 1'b0;
    s_data = wgen(0);
    s_valid = 1'b1;
    en = 1'b1;
    for (int c = 0; c < 1500 && frames_done < 100; c++) begin
      if (s_valid && s_ready) begin
        exp_q.push_back(s_data);
        if (acc >= 2 && (cyc - last_acc) != 12) bad_gap++;
        last_acc = cyc;
        acc++;
        pending = 1'b1;
      end
      tick();
      if (pending) begin
        idx++;
        if (idx < 100) s_data = wgen(idx);
        else s_valid = 1'b0;
        pending = 1'b0;
      end
      if (fs_cnt >= 100) en = 1'b0;
    end
    check("stream_frames", 64'(frames_done), 64'd100);
    check("stream_accepts", 64'(acc), 64'd100);
    check("stream_gap12", 64'(bad_gap), 64'd0);
    check("stream_ur_cnt", 64'(underrun_cnt), 64'd0);
    check("stream_ur_pulses", 64'(ur_pulses), 64'd0);

    // Starve after one word: 5 frames, the last 4 replay it
    do_reset();
    chk = 1'b1;
    s_data = 48'h5A5_0F0_C3C_7E1;
    s_valid = 1'b1;
    en = 1'b1;
    exp_q.push_back(s_data);
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 200 && frames_done < 5; c++) begin
      tick();
      if (fs_cnt >= 5) en = 1'b0;
    end
    check("starve_frames", 64'(frames_done), 64'd5);
    check("starve_pulses", 64'(ur_pulses), 64'd4);
    check("starve_cnt", 64'(underrun_cnt), 64'd4);

    // en dropped at bit 5: frame completes, then idle
    do_reset();
    chk = 1'b1;
    s_data = 48'h9C3_1E2_F00_0FF;
    s_valid = 1'b1;
    en = 1'b1;
    exp_q.push_back(s_data);
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20 && fs_cnt < 1; c++) tick();
    repeat (5) tick();
    en = 1'b0;
    for (int c = 0; c < 20 && frames_done < 1; c++) tick();
    check("endrop_frames", 64'(frames_done), 64'd1);
    check("endrop_fco", 64'(last_fco), 64'hFC0);
    tick();
    check("endrop_idle_out", 64'({din, fco, dco}), 64'h0);
    repeat (12) tick();
    check("endrop_no_more", 64'(fs_cnt), 64'd1);
    check("endrop_still_idle", 64'({din, fco, dco}), 64'h0);

    // Reset asserted at bit 7 of a running frame
    do_reset();
    s_data = 48'hFFF_FFF_FFF_FFF;
    s_valid = 1'b1;
    en = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20 && fs_cnt < 1; c++) tick();
    repeat (7) tick();
    check("midrst_pre_din", 64'(din), 64'hF);
    arstn = 1'b0;
    en = 1'b0;
    tick();
    check("midrst_out", 64'({din, fco, dco, frame_start, underrun}), 64'h0);
    check("midrst_ready", 64'(s_ready), 64'h1);
    arstn = 1'b1;

    // Pattern mode 01 (ramp when enabled, ignored otherwise)
    do_reset();
    pattern_mode = 2'b01;
`ifdef AD9228_TX_PATTERN_EN
    en = 1'b1;
    for (int c = 0; c < 100 && frames_done < 3; c++) begin
      tick();
      if (fs_cnt >= 3) en = 1'b0;
    end
    check("ramp_frames", 64'(frames_done), 64'd3);
    for (int i = 0; i < 3; i++) begin
      w = frames_q[i];
      check("ramp_lane0", 64'(w[11:0]), 64'(i));
      check("ramp_lane1", 64'(w[23:12]), 64'(i + 1));
      check("ramp_lane3", 64'(w[47:36]), 64'(i + 3));
    end
    check("ramp_no_ur", 64'(underrun_cnt), 64'd0);
`else
    chk = 1'b1;
    s_data = 48'h321_654_987_CBA;
    s_valid = 1'b1;
    en = 1'b1;
    exp_q.push_back(s_data);
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 40 && frames_done < 1; c++) begin
      tick();
      if (fs_cnt >= 1) en = 1'b0;
    end
    w = last_frame;
    check("nopat_frames", 64'(frames_done), 64'd1);
    check("nopat_lane0", 64'(w[11:0]), 64'hCBA);
    check("nopat_lane3", 64'(w[47:36]), 64'h321);
`endif
    pattern_mode = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
